// File: rtl/coin_acceptor_pkg.sv
// Shared types and constants for the coin acceptor front end.
package coin_acceptor_pkg;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCEPT  = 2'd1,
    REJECT  = 2'd2,
    LOCKOUT = 2'd3
  } state_t;

  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_SAT = 8'd255;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_SAT) ? v : v + 1'b1;
  endfunction
endpackage

// File: rtl/coin_acceptor_if.sv
// Sensor/control/pulse bundle of the coin acceptor.
// COIN_ACCEPTOR_STATS_EN adds the accepted/rejected counters.
interface coin_acceptor_if;
  import coin_acceptor_pkg::*;
  logic sens_5_raw;
  logic sens_10_raw;
  logic inhibit;
  logic coin_5;
  logic coin_10;
  logic coin_reject;
  logic busy;
`ifdef COIN_ACCEPTOR_STATS_EN
  logic [CNT_W-1:0] accepted_cnt;
  logic [CNT_W-1:0] rejected_cnt;

  modport master (output sens_5_raw, sens_10_raw, inhibit,
                  input  coin_5, coin_10, coin_reject, busy, accepted_cnt, rejected_cnt);
  modport slave  (input  sens_5_raw, sens_10_raw, inhibit,
                  output coin_5, coin_10, coin_reject, busy, accepted_cnt, rejected_cnt);
`else
  modport master (output sens_5_raw, sens_10_raw, inhibit,
                  input  coin_5, coin_10, coin_reject, busy);
  modport slave  (input  sens_5_raw, sens_10_raw, inhibit,
                  output coin_5, coin_10, coin_reject, busy);
`endif
endinterface

// File: rtl/coin_acceptor_debounce.sv
// One sensor channel: 2-flop synchroniser, debounce counter, registered rise event.
module coin_debounce
  import coin_acceptor_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic rise
);
  logic [1:0]       sync;
  logic             level;
  logic [CNT_W-1:0] cnt;

  // Level flips on the DEBOUNCE_CYCLES-th consecutive differing sample.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync  <= '0;
      level <= 1'b0;
      cnt   <= '0;
      rise  <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      rise <= 1'b0;
      if (sync[1] != level) begin
        if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          level <= sync[1];
          cnt   <= '0;
          rise  <= sync[1];
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end
endmodule

// File: rtl/coin_acceptor.sv
// Coin acceptor: debounced sensor arbitration into clean accept/reject pulses.
// COIN_ACCEPTOR_STATS_EN enables saturating accept/reject counters.
module coin_acceptor
  import coin_acceptor_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int LOCKOUT_CYCLES  = 8
) (
  input logic            clk,
  input logic            reset,
  coin_acceptor_if.slave bus
);
  logic ev5, ev10, any_ev;
  state_t state, state_n;
  logic [CNT_W-1:0] lock_cnt, lock_n;
  logic pend, pend_n;
  logic c5_q, c10_q, rej_q, busy_q;
  logic c5_n, c10_n, rej_n;

  coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db5 (
    .clk(clk), .reset(reset), .raw(bus.sens_5_raw), .rise(ev5));
  coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db10 (
    .clk(clk), .reset(reset), .raw(bus.sens_10_raw), .rise(ev10));

  assign any_ev = ev5 | ev10;

  // Pulses are decided on the transition so they appear registered in the new state.
  always_comb begin
    state_n = state;
    lock_n  = lock_cnt;
    pend_n  = pend;
    c5_n    = 1'b0;
    c10_n   = 1'b0;
    rej_n   = 1'b0;
    unique case (state)
      IDLE: begin
        if (any_ev) begin
          if ((ev5 && ev10) || bus.inhibit) begin
            state_n = REJECT;
            rej_n   = 1'b1;
          end else begin
            state_n = ACCEPT;
            c5_n    = ev5;
            c10_n   = ev10;
          end
        end
      end
      ACCEPT, REJECT: begin
        state_n = LOCKOUT;
        lock_n  = CNT_W'(LOCKOUT_CYCLES);
        pend_n  = pend | any_ev;
      end
      LOCKOUT: begin
        if (lock_cnt <= CNT_W'(1)) begin
          lock_n = '0;
          if (pend || any_ev) begin
            state_n = REJECT;
            rej_n   = 1'b1;
            pend_n  = 1'b0;
          end else begin
            state_n = IDLE;
          end
        end else begin
          lock_n = lock_cnt - 1'b1;
          pend_n = pend | any_ev;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      lock_cnt <= '0;
      pend     <= 1'b0;
      c5_q     <= 1'b0;
      c10_q    <= 1'b0;
      rej_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state    <= state_n;
      lock_cnt <= lock_n;
      pend     <= pend_n;
      c5_q     <= c5_n;
      c10_q    <= c10_n;
      rej_q    <= rej_n;
      busy_q   <= (state_n != IDLE);
    end
  end

  assign bus.coin_5      = c5_q;
  assign bus.coin_10     = c10_q;
  assign bus.coin_reject = rej_q;
  assign bus.busy        = busy_q;

`ifdef COIN_ACCEPTOR_STATS_EN
  logic [CNT_W-1:0] acc_cnt, rej_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_cnt <= '0;
      rej_cnt <= '0;
    end else begin
      if (c5_q || c10_q) acc_cnt <= sat_inc(acc_cnt);
      if (rej_q)         rej_cnt <= sat_inc(rej_cnt);
    end
  end

  assign bus.accepted_cnt = acc_cnt;
  assign bus.rejected_cnt = rej_cnt;
`endif
endmodule

// File: tb/tb_coin_acceptor.sv
// Directed bench for coin_acceptor with DEBOUNCE_CYCLES=4, LOCKOUT_CYCLES=8.
module tb_coin_acceptor;
  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   nchk = 0;
  int   nerr = 0;
  int   n5, n10, nrej, f5, f10, frej, excl_bad;
  int   k, r;

  coin_acceptor_if bus ();

  coin_acceptor #(.DEBOUNCE_CYCLES(4), .LOCKOUT_CYCLES(8)) dut (
    .clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse log, sampled mid-cycle; cyc here is the cycle number of the pulse.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.coin_5)      begin if (n5 == 0)   f5   = cyc; n5++;   end
      if (bus.coin_10)     begin if (n10 == 0)  f10  = cyc; n10++;  end
      if (bus.coin_reject) begin if (nrej == 0) frej = cyc; nrej++; end
      if (32'(bus.coin_5) + 32'(bus.coin_10) + 32'(bus.coin_reject) > 1) excl_bad++;
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic clear_log();
    n5 = 0; n10 = 0; nrej = 0; f5 = -1; f10 = -1; frej = -1;
  endtask

  task automatic wait_to(input int t);
    int guard = 0;
    while (cyc < t && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    if (cyc != t) check("wait_to", cyc, t);
  endtask

  initial begin
    excl_bad = 0;
    clear_log();
    reset = 1'b1;
    bus.sens_5_raw = 1'b0; bus.sens_10_raw = 1'b0; bus.inhibit = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_coin5",  bus.coin_5, 0);
    check("rst_coin10", bus.coin_10, 0);
    check("rst_reject", bus.coin_reject, 0);
    check("rst_busy",   bus.busy, 0);
    check("rst_state",  32'(dut.state), 0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // clean 5-unit coin
    clear_log();
    k = cyc; bus.sens_5_raw = 1'b1;
    wait_to(k + 6);
    check("s1_busy_pre", bus.busy, 0);
    check("s1_c5_pre", bus.coin_5, 0);
    wait_to(k + 7);
    check("s1_c5", bus.coin_5, 1);
    check("s1_busy_first", bus.busy, 1);
    wait_to(k + 8);
    check("s1_c5_off", bus.coin_5, 0);
    wait_to(k + 15);
    check("s1_busy_last", bus.busy, 1);
    wait_to(k + 16);
    check("s1_busy_off", bus.busy, 0);
    wait_to(k + 20); bus.sens_5_raw = 1'b0;
    wait_to(k + 40);
    check("s1_n5", n5, 1);
    check("s1_f5", f5, k + 7);
    check("s1_nrej", nrej, 0);
    check("s1_n10", n10, 0);

    // bounce on the 10-unit sensor
    clear_log();
    k = cyc;
    for (int i = 0; i < 12; i++) begin
      bus.sens_10_raw = ((i / 2) % 2 == 0);
      @(negedge clk);
    end
    bus.sens_10_raw = 1'b1;
    wait_to(k + 30); bus.sens_10_raw = 1'b0;
    wait_to(k + 50);
    check("s2_n10", n10, 1);
    check("s2_f10", f10, k + 19);
    check("s2_nrej", nrej, 0);
    check("s2_n5", n5, 0);

    // simultaneous coins
    clear_log();
    k = cyc; bus.sens_5_raw = 1'b1; bus.sens_10_raw = 1'b1;
    wait_to(k + 20);
    check("s3_nrej", nrej, 1);
    check("s3_frej", frej, k + 7);
    check("s3_n5", n5, 0);
    check("s3_n10", n10, 0);
    bus.sens_5_raw = 1'b0; bus.sens_10_raw = 1'b0;
    wait_to(k + 40);

    // inhibit
    clear_log();
    bus.inhibit = 1'b1;
    k = cyc; bus.sens_5_raw = 1'b1;
    wait_to(k + 7);
    check("s4_reject", bus.coin_reject, 1);
    wait_to(k + 20);
    check("s4_n5", n5, 0);
    check("s4_nrej", nrej, 1);
    bus.sens_5_raw = 1'b0;
    wait_to(k + 30); bus.inhibit = 1'b0;
    wait_to(k + 40);

    // second coin lands 3 cycles into lockout
    clear_log();
    k = cyc; bus.sens_10_raw = 1'b1;
    wait_to(k + 4); bus.sens_5_raw = 1'b1;
    wait_to(k + 25);
    check("s5_n10", n10, 1);
    check("s5_f10", f10, k + 7);
    check("s5_n5", n5, 0);
    check("s5_nrej", nrej, 1);
    check("s5_frej", frej, k + 16);
    bus.sens_5_raw = 1'b0; bus.sens_10_raw = 1'b0;
    wait_to(k + 45);

    // reset while in ACCEPT, sensor held through release
    clear_log();
    k = cyc; bus.sens_5_raw = 1'b1;
    wait_to(k + 7);
    check("s6_c5_pre", bus.coin_5, 1);
    reset = 1'b1;
    #1;
    check("s6_c5_rst", bus.coin_5, 0);
    check("s6_busy_rst", bus.busy, 0);
    check("s6_state_rst", 32'(dut.state), 0);
    wait_to(k + 10);
    clear_log();
    r = cyc; reset = 1'b0;
    wait_to(k + 30);
    check("s6_n5", n5, 1);
    check("s6_f5", f5, r + 7);
    bus.sens_5_raw = 1'b0;
    wait_to(k + 50);

`ifdef COIN_ACCEPTOR_STATS_EN
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("st_acc_rst", bus.accepted_cnt, 0);
    check("st_rej_rst", bus.rejected_cnt, 0);
    clear_log();
    repeat (5) @(negedge clk);
    for (int i = 0; i < 260; i++) begin
      k = cyc; bus.sens_5_raw = 1'b1;
      wait_to(k + 10); bus.sens_5_raw = 1'b0;
      wait_to(k + 22);
    end
    check("st_n5", n5, 260);
    check("st_acc_sat", bus.accepted_cnt, 255);
    check("st_rej", bus.rejected_cnt, 0);
`endif

    check("exclusive", excl_bad, 0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule

// File: doc/coin_acceptor.md
# coin_acceptor

Front-end coin validation stage feeding the vending-machine FSM. Takes the two raw, asynchronous, bouncing coin-sensor lines, then synchronises and debounces them. It arbitrates illegal or too-fast insertions and emits clean single-cycle `coin_5` / `coin_10` pulses that drive the FSM's coin inputs directly. Rejected insertions raise a `coin_reject` pulse for the coin-return gate.

## Interface
- `DEBOUNCE_CYCLES`, default 16: consecutive stable synchronised samples required to change a debounced level; legal range 2..255.
- `LOCKOUT_CYCLES`, default 8: guard interval after any accept or reject; legal range 1..255.
- `clk` input 1: system clock.
- `reset` input 1: asynchronous, active-high.
- `sens_5_raw` input 1: raw 5-unit sensor, asynchronous to `clk`, high while a coin is present.
- `sens_10_raw` input 1: raw 10-unit sensor, same properties.
- `inhibit` input 1: from downstream, high when the FSM must not take coins (dispense cycle).
- `coin_5` output 1: one-cycle pulse, accepted 5-unit coin.
- `coin_10` output 1: one-cycle pulse, accepted 10-unit coin.
- `coin_reject` output 1: one-cycle pulse, insertion rejected.
- `busy` output 1: high while in ACCEPT, REJECT or LOCKOUT.
- `accepted_cnt` output 8: present only with the stats feature; see Configuration.
- `rejected_cnt` output 8: present only with the stats feature; see Configuration.

## Operation
- **Synchroniser.** Each raw line passes through a 2-flop synchroniser, reset to 0.
- **Debouncer (per channel).**
  - Holds a debounced level, reset to 0, and a counter.
  - While the synchronised sample differs from the debounced level, the counter increments; otherwise it clears.
  - When the counter reaches `DEBOUNCE_CYCLES`, the level flips and the counter clears.
  - A rising debounced edge produces a one-cycle event; falling edges produce nothing.
- **FSM states.** IDLE, ACCEPT, REJECT, LOCKOUT.
- **IDLE transitions.**
  - Exactly one event with `inhibit` low goes to ACCEPT, latching the channel.
  - Both events in the same cycle go to REJECT.
  - Any event with `inhibit` high goes to REJECT.
  - No event stays in IDLE.
- **ACCEPT.** Asserts the latched `coin_5` or `coin_10` for exactly one cycle, then goes to LOCKOUT.
- **REJECT.** Asserts `coin_reject` for one cycle, then goes to LOCKOUT.
- **LOCKOUT.**
  - The counter loads `LOCKOUT_CYCLES` on entry and decrements each cycle; the FSM returns to IDLE when it reaches 0.
  - Any event arriving during LOCKOUT is recorded in a pending-reject flag.
  - On exit, if the flag is set, the FSM goes to REJECT instead of IDLE and clears the flag. Multiple events during lockout still produce only one reject.
- **Output exclusivity.** `coin_5`, `coin_10` and `coin_reject` are mutually exclusive in every cycle.
- **Reset mid-operation.** All state is cleared immediately and no pulse is emitted. A sensor held high through reset release is treated as a new coin: it is debounced and accepted.

## Timing
- **Reset values.** All outputs are 0 during reset. The FSM is in IDLE and all counters are 0.
- **Accept latency.**
  - A raw line is taken high and held from clock edge k.
  - The debounced rise occurs at edge k+2+`DEBOUNCE_CYCLES`, and the FSM enters ACCEPT at the following edge.
  - The coin pulse is therefore high in cycle k+3+`DEBOUNCE_CYCLES`.
- **Reject latency.** Identical to accept latency.
- **Minimum spacing.** Two pulses are at least `LOCKOUT_CYCLES`+1 cycles apart.
- **Glitch filtering.** A glitch shorter than `DEBOUNCE_CYCLES` synchronised cycles never produces an event.
- **`inhibit` sampling.** Sampled only in IDLE, in the same cycle as the event.
- **Outputs.** All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- **`COIN_ACCEPTOR_STATS_EN` defined.**
  - Adds ports `accepted_cnt` and `rejected_cnt`, both reset to 0.
  - Each is an 8-bit counter that increments on the cycle its pulse is high and saturates at 255 (no wrap).
- **`COIN_ACCEPTOR_STATS_EN` undefined.** Neither the counters nor the ports exist; all other behaviour is identical.

## Structure
- **Package `coin_acceptor_pkg`.**
  - State encoding constants (IDLE=0, ACCEPT=1, REJECT=2, LOCKOUT=3).
  - Counter width constant (8) and the saturation value.
- **Sub-module `coin_debounce`.**
  - Instantiated twice, one per channel.
  - Contains the synchroniser, the debounce counter and the rising-edge event output.
  - Parameterised by `DEBOUNCE_CYCLES`.
- **Top level.** FSM, lockout counter, pending-reject flag and optional stats counters.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4 and `LOCKOUT_CYCLES`=8.
- **Clean 5-unit coin.** `sens_5_raw` high from edge 10 for 20 cycles -> `coin_5` high only in cycle 17, `busy` high in cycles 17..25, no reject.
- **Bounce.** `sens_10_raw` toggled every 2 cycles for 12 cycles, then held high -> exactly one `coin_10` pulse, 7 cycles after the final stable rise.
- **Simultaneous coins.** Both raw lines high at the same edge -> a single `coin_reject` pulse, no coin pulse.
- **Inhibit.** `inhibit` high, then a 5-unit coin -> `coin_reject` at accept latency, `coin_5` stays 0.
- **Coin during lockout.** 10-unit coin accepted, then a second 5-unit coin whose debounced event falls 3 cycles into LOCKOUT -> `coin_reject` one cycle after LOCKOUT ends, no `coin_5`.
- **Reset and saturation.**
  - Reset asserted while in ACCEPT -> outputs immediately 0, FSM in IDLE.
  - With `COIN_ACCEPTOR_STATS_EN` defined, 260 accepts -> `accepted_cnt` reads 255.
